// File: rtl/bitty_program_loader.sv
// Loads a length-prefixed, big-endian byte stream into bitty instruction memory, then releases the core.
// Build option LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and drives load_error.
module bitty_program_loader (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   input  logic        start,
   output logic        mem_we,
   output logic [7:0]  mem_addr,
   output logic [15:0] mem_wdata,
   output logic        cpu_run,
   output logic        load_error
);
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_LEN,
      S_HI,
      S_LO,
      S_WRITE,
      S_CHK,
      S_DONE
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   n_words;
   logic [BYTE_W-1:0]  hi_byte;
   logic               take;
   logic               last_word;

   // Handshake is combinational so a held byte is accepted in the same cycle it is offered.
   assign rx_ready  = !reset && (state == S_LEN || state == S_HI ||
                                 state == S_LO  || state == S_CHK);
   assign take      = rx_valid && rx_ready;
   assign last_word = ({1'b0, mem_addr} == (n_words - CNT_W'(1)));

`ifdef LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0]  xor_acc;
`else
   assign load_error = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_LEN;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_run   <= 1'b0;
         n_words   <= '0;
         hi_byte   <= '0;
`ifdef LOADER_CHECKSUM_EN
         xor_acc    <= '0;
         load_error <= 1'b0;
`endif
      end else begin
         mem_we <= 1'b0;
         case (state)
            S_LEN: begin
               if (take) begin
                  // A length byte of zero encodes a full 256-word image.
                  n_words  <= (rx_data == 8'd0) ? CNT_W'(256) : {1'b0, rx_data};
                  mem_addr <= '0;
                  state    <= S_HI;
               end
            end
            S_HI: begin
               if (take) begin
                  hi_byte <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                  xor_acc <= xor_acc ^ rx_data;
`endif
                  state   <= S_LO;
               end
            end
            S_LO: begin
               if (take) begin
                  mem_wdata <= {hi_byte, rx_data};
                  mem_we    <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  xor_acc   <= xor_acc ^ rx_data;
`endif
                  state     <= S_WRITE;
               end
            end
            S_WRITE: begin
               // Exit compare fires at 255 for N=256, so the address never wraps.
               if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                  state   <= S_CHK;
`else
                  state   <= S_DONE;
                  cpu_run <= 1'b1;
`endif
               end else begin
                  mem_addr <= mem_addr + ADDR_W'(1);
                  state    <= S_HI;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
               if (take) begin
                  if (rx_data != xor_acc) begin
                     load_error <= 1'b1;
                     cpu_run    <= 1'b0;
                  end else begin
                     cpu_run    <= 1'b1;
                  end
                  state <= S_DONE;
               end
            end
`endif
            S_DONE: begin
               if (start) begin
                  state    <= S_LEN;
                  cpu_run  <= 1'b0;
                  mem_addr <= '0;
`ifdef LOADER_CHECKSUM_EN
                  xor_acc    <= '0;
                  load_error <= 1'b0;
`endif
               end
            end
            default: state <= S_LEN;
         endcase
      end
   end
endmodule

// File: doc/bitty_program_loader.md
# bitty_program_loader

Byte-stream instruction loader that writes 16-bit instructions into the bitty instruction memory before the core starts fetching. It accepts a length-prefixed, big-endian byte stream over a valid/ready handshake, typically fed by a UART receiver. It assembles each pair of bytes into one instruction word and issues one write per word at consecutive addresses from 0. When loading completes it raises `cpu_run`, which releases the program counter and fetch path.

## Interface
- No parameters; widths fixed: address 8 bits, instruction 16 bits, stream byte 8 bits.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  incoming stream byte.
- `rx_valid`  in  1  `rx_data` valid this cycle.
- `rx_ready`  out  1  loader can accept a byte this cycle.
- `start`  in  1  restart request; honoured only in DONE.
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr`  out  8  write address.
- `mem_wdata`  out  16  write data, `{hi_byte, lo_byte}`.
- `cpu_run`  out  1  high when the program is loaded without error; holds the core in reset while low.
- `load_error`  out  1  checksum mismatch (only with the checksum build option).

## Operation
- A byte transfers on any cycle where `rx_valid && rx_ready`. Bytes offered while `rx_ready` is low are neither consumed nor lost; the source holds them.
- Stream format: `LEN`, then `2*N` data bytes (high byte first per word), then optionally `CHK`. N = `LEN`, except `LEN` = 0 means N = 256.
- States:
  - LEN: accept the length byte, store 9-bit N, clear `mem_addr`, go to HI.
  - HI: accept a byte into the high register, go to LO.
  - LO: accept a byte into the low register, go to WRITE.
  - WRITE: `mem_we`=1 for one cycle with `mem_wdata`={hi,lo} at `mem_addr`. If `mem_addr`==N-1, go to CHK (option built in) or DONE. Otherwise increment `mem_addr` and go to HI.
  - CHK: accept one byte and compare it with the running XOR of all data bytes. Mismatch sets `load_error`. Go to DONE.
  - DONE: `cpu_run` = !`load_error`. Stay until `start`=1, then go to LEN and clear `load_error`, `cpu_run`, `mem_addr` and the XOR accumulator.
- `rx_ready`=1 in LEN, HI, LO and CHK; 0 in WRITE and DONE; forced 0 while `reset` is high.
- `mem_addr` is 8-bit. For N=256 the last write is at 255; the increment never wraps back to 0 because the exit compare fires first.
- The word counter compare uses the 9-bit N; N-1 is computed in 9 bits.
- `start` is ignored outside DONE.

## Timing
- Reset values: state LEN; `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_run`=0, `load_error`=0, XOR accumulator = 0.
- Per word: 3 cycles minimum (HI, LO, WRITE) with `rx_valid` held high. Full load takes 1 + 3N (+1 with CHK) cycles, followed by DONE.
- `mem_we` rises the cycle after the LO byte is accepted. `mem_addr` and `mem_wdata` are stable for that cycle.
- `cpu_run` rises the first cycle in DONE, which is 1 cycle after the last write, or after the CHK byte is accepted.
- Reset asserted mid-load: next edge returns to LEN with all outputs at reset values. No further write occurs. Memory is not cleared, so already-written words remain.
- `start` and `rx_valid` high in the same DONE cycle: go to LEN; that byte is not consumed because `rx_ready`=0 in DONE.

## Configuration
- `LOADER_CHECKSUM_EN` defined: CHK state present. A trailing XOR checksum byte is required, `load_error` is driven, and a mismatch keeps `cpu_run`=0.
- Not defined: no CHK state. WRITE of the last word goes directly to DONE, `load_error` is tied to 0, and the accumulator is removed.

## Test plan
- Stream `02, 12,34, AB,CD` with `rx_valid` held high -> writes `1234`@0 and `ABCD`@1, `mem_we` pulses exactly twice, `cpu_run`=1 on cycle 8 after the first byte.
- `rx_valid` toggling 1/0 every cycle on the same stream -> identical writes; no byte dropped or duplicated.
- `LEN`=00 with 512 data bytes where word i = `{i, ~i}` -> 256 writes at 0..255, last write `FF00`@255, then DONE.
- Checksum option: `01, 0F,F0, FF` -> write `0FF0`@0, `cpu_run`=1. Same stream with `CHK`=`00` -> `load_error`=1, `cpu_run`=0. Then `start` -> `load_error` cleared and a new load accepted.
- Reset asserted after `03, AA,BB, CC` -> single write `AABB`@0 only. Next stream `01, 55,66` -> writes `5566`@0, `cpu_run`=1.
- In DONE, `rx_valid`=1 with `start`=0 -> `rx_ready`=0, no writes, state held.
